// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave
//   AHB-Lite slave in front of a word-organised internal SRAM. Address and
//   data phases are pipelined, every OKAY data phase is stretched by
//   WAIT_STATES low cycles, writes touch only the byte lanes selected by
//   HSIZE/HADDR, and illegal transfers get the two-cycle ERROR response.
//
//   Ports
//     HCLK, HRESET (async, active low)
//     HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HREADY : address phase
//     HWDATA                                                    : write data (data phase)
//     HRDATA, HREADYOUT, HRESP                                  : response to the HREADY mux
module ahb_lite_sram_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_WORDS   = 1024,
  parameter int                    WAIT_STATES = 0,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int LOG2B = $clog2(NB);
  localparam int IDXW  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  // one past the last valid byte; extra bit so BASE+size cannot wrap
  localparam logic [ADDR_WIDTH:0] LIMIT =
    {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(MEM_WORDS * NB);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  // ---------------- address-phase decode ----------------
  logic                  w_accept;
  logic                  w_size_bad, w_misalign, w_range_bad, w_bad;
  logic [ADDR_WIDTH-1:0] w_mask, w_off;
  logic [IDXW-1:0]       w_word;
  logic [LOG2B-1:0]      w_lo;
  logic [NB-1:0]         w_be;

  assign w_accept    = HSEL & HREADY & HTRANS[1];
  assign w_size_bad  = (HSIZE > 3'(LOG2B));
  assign w_mask      = ~({ADDR_WIDTH{1'b1}} << HSIZE);
  assign w_misalign  = |(HADDR & w_mask);
  assign w_range_bad = ({1'b0, HADDR} < {1'b0, BASE_ADDR}) || ({1'b0, HADDR} >= LIMIT);
  assign w_bad       = w_size_bad | w_misalign | w_range_bad;
  assign w_off       = HADDR - BASE_ADDR;
  assign w_word      = w_off[LOG2B +: IDXW];
  assign w_lo        = HADDR[LOG2B-1:0];

  // lanes [lo, lo + 2^HSIZE); alignment is already checked, so no wrap
  always_comb begin
    w_be = '0;
    for (int i = 0; i < NB; i++)
      w_be[i] = (i >= int'(w_lo)) && (i < int'(w_lo) + (1 << HSIZE));
  end

  // ---------------- FSM ----------------
  state_t          r_state;
  state_t          w_nxt;
  logic            w_take;
  logic [3:0]      r_wcnt;
  logic            r_write;
  logic [IDXW-1:0] r_word;
  logic [NB-1:0]   r_be;
  logic            r_rdy, r_resp;

  always_comb begin
    w_nxt  = r_state;
    w_take = 1'b0;
    unique case (r_state)
      S_WAIT:  if (r_wcnt == 4'd1) w_nxt = S_DATA;
      S_ERR1:  w_nxt = S_ERR2;                    // master's IDLE here is ignored
      default: begin                              // IDLE, DATA, ERR2 all take new addr phases
        if (w_accept) begin
          w_take = 1'b1;
          if (w_bad)                w_nxt = S_ERR1;
          else if (WAIT_STATES > 0) w_nxt = S_WAIT;
          else                      w_nxt = S_DATA;
        end else begin
          w_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_write <= 1'b0;
      r_word  <= '0;
      r_be    <= '0;
      r_rdy   <= 1'b1;
      r_resp  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      // outputs registered from the next state so they line up with r_state
      r_rdy   <= (w_nxt != S_WAIT) && (w_nxt != S_ERR1);
      r_resp  <= (w_nxt == S_ERR1) || (w_nxt == S_ERR2);
      if (r_state == S_WAIT) r_wcnt <= r_wcnt - 4'd1;
      if (w_take) begin
        r_write <= HWRITE;
        r_word  <= w_word;
        r_be    <= w_be;
        r_wcnt  <= 4'(WAIT_STATES);
      end
    end
  end

  // ---------------- memory, one byte-wide array per lane ----------------
  // Write commits on the edge closing the data phase, so a read whose data
  // phase follows directly sees the new bytes through the async read port.
  logic                 w_commit;
  logic [NB-1:0][7:0]   w_rd;

  assign w_commit = (r_state == S_DATA) && r_write;

  for (genvar g = 0; g < NB; g++) begin : g_lane
    logic [7:0] r_mem [MEM_WORDS];
    always_ff @(posedge HCLK)
      if (w_commit && r_be[g]) r_mem[r_word] <= HWDATA[8*g +: 8];
    assign w_rd[g] = r_mem[r_word];
  end

  assign HRDATA    = ((r_state == S_DATA) && !r_write) ? w_rd : '0;
  assign HREADYOUT = r_rdy;
  assign HRESP     = r_resp;

  logic w_unused_ok;
  assign w_unused_ok = ^{HBURST, HPROT, HTRANS[0], w_off};

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench: two slaves on one bus (dut0: 0 wait states, base 0; dut1: 2 wait
// states, base 0x1000). A pipelined master drives a command queue; each
// address phase pushes a predicted response to the scoreboard, which is
// popped when the matching data phase completes.
module tb_ahb_lite_sram_slave;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [1:0]    hsel;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE, HBURST;
  logic [3:0]    HPROT;
  logic [DW-1:0] HWDATA;
  logic          dsel;
  logic [DW-1:0] rdata0, rdata1, w_rdata;
  logic          rdy0, rdy1, resp0, resp1, w_rdy, w_resp;

  assign w_rdy   = dsel ? rdy1   : rdy0;
  assign w_resp  = dsel ? resp1  : resp0;
  assign w_rdata = dsel ? rdata1 : rdata0;

  always #5 HCLK = ~HCLK;

  ahb_lite_sram_slave #(.WAIT_STATES(0), .BASE_ADDR(32'h0)) u_dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[0]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(w_rdy), .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(resp0));

  ahb_lite_sram_slave #(.WAIT_STATES(2), .BASE_ADDR(32'h1000)) u_dut1 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[1]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(w_rdy), .HRDATA(rdata1), .HREADYOUT(rdy1), .HRESP(resp1));

  typedef struct packed {
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
    logic [3:0]  waits;
  } exp_t;

  cmd_t      cq[$];
  exp_t      sb[$];
  bit [31:0] mdl [int];
  int        n_chk = 0;
  int        n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t predict(input cmd_t c);
    exp_t        e;
    logic [31:0] base, cur;
    int          key, nb, lo;
    base    = dsel ? 32'h1000 : 32'h0;
    nb      = 1 << c.sz;
    e.err   = (c.sz > 3'd2) || ((c.addr % nb) != 0) ||
              (c.addr < base) || (c.addr >= base + 32'd4096);
    e.waits = e.err ? 4'd1 : (dsel ? 4'd2 : 4'd0);
    e.data  = '0;
    if (!e.err) begin
      key = int'(dsel) * 65536 + int'((c.addr - base) >> 2);
      cur = mdl.exists(key) ? mdl[key] : 32'h0;
      lo  = int'(c.addr[1:0]);
      if (c.wr) begin
        for (int i = 0; i < 4; i++)
          if (i >= lo && i < lo + nb) cur[8*i +: 8] = c.wdata[8*i +: 8];
        mdl[key] = cur;
      end else begin
        e.data = cur;
      end
    end
    return e;
  endfunction

  task automatic drive_idle();
    hsel = 2'b00; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0; HADDR = '0;
  endtask

  task automatic drive_ap(input bit v, input cmd_t c);
    if (v) begin
      hsel = dsel ? 2'b10 : 2'b01;
      HTRANS = 2'b10; HWRITE = c.wr; HSIZE = c.sz; HADDR = c.addr;
    end else begin
      drive_idle();
    end
  endtask

  task automatic add(input bit wr, input logic [2:0] sz, input logic [31:0] addr,
                     input logic [31:0] wdata);
    cmd_t c;
    c.wr = wr; c.sz = sz; c.addr = addr; c.wdata = wdata;
    cq.push_back(c);
  endtask

  // Pipelined master; entered and left just after a rising edge, bus idle.
  task automatic run(input string name);
    cmd_t ap, dp;
    bit   ap_v = 0, dp_v = 0;
    exp_t de;
    int   lowc = 0, k = 0, budget = 200;
    logic rdy;
    ap = '0; dp = '0;
    if (cq.size() > 0) begin
      ap = cq.pop_front(); ap_v = 1; sb.push_back(predict(ap));
    end
    drive_ap(ap_v, ap);
    while ((ap_v || dp_v) && budget > 0) begin
      budget--;
      @(negedge HCLK);
      rdy = w_rdy;
      if (dp_v) begin
        if (!rdy) begin
          lowc++;
          chk($sformatf("%s_%0d_lowresp", name, k), w_resp, sb[0].err);
          chk($sformatf("%s_%0d_lowrdata", name, k), w_rdata, 0);
        end else begin
          de = sb.pop_front();
          chk($sformatf("%s_%0d_resp", name, k), w_resp, de.err);
          chk($sformatf("%s_%0d_waits", name, k), lowc, de.waits);
          chk($sformatf("%s_%0d_rdata", name, k), w_rdata, de.data);
          k++;
        end
      end else begin
        chk($sformatf("%s_idle_rdy", name), rdy, 1);
      end
      @(posedge HCLK); #1;
      if (rdy) begin
        lowc = 0;
        dp_v = ap_v; dp = ap;
        if (cq.size() > 0) begin
          ap = cq.pop_front(); ap_v = 1; sb.push_back(predict(ap));
        end else begin
          ap_v = 0;
        end
        drive_ap(ap_v, ap);
        HWDATA = (dp_v && dp.wr) ? dp.wdata : '0;
      end
    end
    if (budget == 0) chk({name, "_timeout"}, 1, 0);
  endtask

  task automatic idle_chk(input string tag);
    @(negedge HCLK);
    chk({tag, "_rdy"}, w_rdy, 1);
    chk({tag, "_resp"}, w_resp, 0);
    chk({tag, "_rdata"}, w_rdata, 0);
    @(posedge HCLK); #1;
  endtask

  initial begin
    HRESET = 1'b0; dsel = 1'b0; HBURST = 3'd0; HPROT = 4'd0; HWDATA = '0;
    drive_idle();
    #12;
    chk("rst_rdy0", rdy0, 1);   chk("rst_resp0", resp0, 0); chk("rst_rdata0", rdata0, 0);
    chk("rst_rdy1", rdy1, 1);   chk("rst_resp1", resp1, 0); chk("rst_rdata1", rdata1, 0);
    @(negedge HCLK) HRESET = 1'b1;
    @(posedge HCLK); #1;

    // zero-wait write then read, back to back
    add(1, 3'd2, 32'h10, 32'hDEADBEEF); add(0, 3'd2, 32'h10, 0);
    run("t2");
    // byte lane write, then read-after-write in the next data phase
    add(1, 3'd0, 32'h13, 32'hAB000000); add(0, 3'd2, 32'h10, 0);
    run("t3");
    add(1, 3'd2, 32'h14, 32'h0); add(1, 3'd1, 32'h16, 32'h12340000);
    add(1, 3'd0, 32'h14, 32'h000000CD); add(0, 3'd2, 32'h14, 0);
    run("t3b");
    // errors: out of range, misaligned halfword, oversized; memory intact
    add(0, 3'd2, 32'h1000, 0); add(1, 3'd1, 32'h11, 32'hFFFFFFFF);
    add(0, 3'd3, 32'h18, 0);   add(0, 3'd2, 32'h10, 0);
    run("t5");
    idle_chk("t5_idle");

    // async reset in the middle of a read data phase
    hsel = 2'b01; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'd2; HADDR = 32'h10;
    @(posedge HCLK); #1;
    drive_idle();
    #1 chk("t1_pre_rdata", w_rdata, 32'hABADBEEF);
    #1 HRESET = 1'b0;
    #1 chk("t1_rdy", w_rdy, 1); chk("t1_resp", w_resp, 0); chk("t1_rdata", w_rdata, 0);
    @(negedge HCLK) HRESET = 1'b1;
    @(posedge HCLK); #1;

    // two wait states, back-to-back reads held across the waits
    dsel = 1'b1;
    add(1, 3'd2, 32'h1020, 32'h11223344); add(1, 3'd2, 32'h1024, 32'hCAFEF00D);
    add(0, 3'd2, 32'h1024, 0);            add(0, 3'd2, 32'h1020, 0);
    add(0, 3'd2, 32'h0FFC, 0);            add(0, 3'd2, 32'h2000, 0);
    add(0, 3'd1, 32'h1022, 0);
    run("t4");
    idle_chk("t4_idle");

    // reset during the wait of a write: write must not land
    hsel = 2'b10; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = 32'h1020;
    @(posedge HCLK); #1;
    drive_idle(); HWDATA = 32'h55667788;
    @(negedge HCLK) chk("t6_wait_rdy", w_rdy, 0);
    #1 HRESET = 1'b0;
    #1 chk("t6_rdy", w_rdy, 1); chk("t6_resp", w_resp, 0); chk("t6_rdata", w_rdata, 0);
    @(negedge HCLK) HRESET = 1'b1;
    @(posedge HCLK); #1;
    HWDATA = '0;
    add(0, 3'd2, 32'h1020, 0);
    run("t6_rb");
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end
endmodule
